// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe.
// The pipeline takes the slave modport; the producer/consumer side takes master.
interface fp_mul_pipe_if #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         out_unf;

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_unf
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined multiplier for a small float format (no inf/NaN/denormals).
// Define FP_MUL_ROUND_EN for round-to-nearest-even; otherwise discarded bits are truncated.
module fp_mul_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 4,
    parameter int BIAS  = 2**(EXP_W-1)-1
) (
    input logic          clk,
    input logic          rst_n,
    fp_mul_pipe_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2*MAN_W + 2;
    localparam int XW = EXP_W + 2;
    // One extra exponent bit past S1 so the two possible +1 increments never wrap.
    localparam int NW = EXP_W + 3;
    localparam logic signed [NW-1:0] EXP_MAX = NW'(2**EXP_W - 1);
    localparam logic signed [NW-1:0] EXP_MIN = NW'(1);

    logic stall;
    logic advance;

    logic [EXP_W-1:0]     a_exp, b_exp;
    logic [MAN_W-1:0]     a_man, b_man;
    logic [PW-1:0]        a_sig, b_sig;
    logic signed [XW-1:0] exp_sum;

    logic                 s1_valid, s1_sign, s1_zero;
    logic [PW-1:0]        s1_prod;
    logic signed [XW-1:0] s1_exp;

    logic [PW-1:0]        norm_next;
    logic signed [NW-1:0] exp_norm;

    logic                 s2_valid, s2_sign, s2_zero;
    logic [PW-1:0]        s2_norm;
    logic signed [NW-1:0] s2_exp;

    logic [MAN_W-1:0]     man_kept;
    logic [MAN_W-1:0]     man_fin;
    logic signed [NW-1:0] exp_fin;
    logic [W-1:0]         res_data;
    logic                 res_ovf, res_unf;

    assign stall        = bus.out_valid & ~bus.out_ready;
    assign advance      = ~stall;
    assign bus.in_ready = advance;

    assign a_exp   = bus.in_a[W-2:MAN_W];
    assign b_exp   = bus.in_b[W-2:MAN_W];
    assign a_man   = bus.in_a[MAN_W-1:0];
    assign b_man   = bus.in_b[MAN_W-1:0];
    assign a_sig   = {{(MAN_W+1){1'b0}}, 1'b1, a_man};
    assign b_sig   = {{(MAN_W+1){1'b0}}, 1'b1, b_man};
    assign exp_sum = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - $signed(XW'(BIAS));

    // Normalising left-aligns the product instead of shifting right, so no low bit is lost.
    assign norm_next = s1_prod[PW-1] ? s1_prod : {s1_prod[PW-2:0], 1'b0};
    assign exp_norm  = $signed({s1_exp[XW-1], s1_exp})
                     + $signed({{(NW-1){1'b0}}, s1_prod[PW-1]});

    assign man_kept = s2_norm[PW-2 -: MAN_W];

`ifdef FP_MUL_ROUND_EN
    logic             guard, sticky, round_up, carry;
    logic [MAN_W:0]   man_sum;
    logic             unused_lead;

    assign guard       = s2_norm[MAN_W];
    assign sticky      = |s2_norm[MAN_W-1:0];
    assign round_up    = guard & (sticky | man_kept[0]);
    assign man_sum     = {1'b0, man_kept} + {{MAN_W{1'b0}}, round_up};
    // A carry out leaves the kept field all-zero, which is already the renormalised mantissa.
    assign carry       = man_sum[MAN_W];
    assign man_fin     = man_sum[MAN_W-1:0];
    assign exp_fin     = s2_exp + $signed({{(NW-1){1'b0}}, carry});
    assign unused_lead = s2_norm[PW-1];
`else
    logic unused_low;

    assign man_fin    = man_kept;
    assign exp_fin    = s2_exp;
    assign unused_low = ^{s2_norm[PW-1], s2_norm[MAN_W:0]};
`endif

    always_comb begin
        res_data = '0;
        res_ovf  = 1'b0;
        res_unf  = 1'b0;
        if (s2_zero) begin
            res_data = '0;
        end else if (exp_fin > EXP_MAX) begin
            res_data = {s2_sign, {(W-1){1'b1}}};
            res_ovf  = 1'b1;
        end else if (exp_fin < EXP_MIN) begin
            res_unf  = 1'b1;
        end else begin
            res_data = {s2_sign, exp_fin[EXP_W-1:0], man_fin};
        end
    end

    // Every stage moves together; a stalled output freezes the whole pipe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid      <= 1'b0;
            s2_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_unf   <= 1'b0;
        end else if (advance) begin
            s1_valid      <= bus.in_valid;
            s1_sign       <= bus.in_a[W-1] ^ bus.in_b[W-1];
            s1_zero       <= (a_exp == '0) || (b_exp == '0);
            s1_prod       <= a_sig * b_sig;
            s1_exp        <= exp_sum;

            s2_valid      <= s1_valid;
            s2_sign       <= s1_sign;
            s2_zero       <= s1_zero;
            s2_norm       <= norm_next;
            s2_exp        <= exp_norm;

            bus.out_valid <= s2_valid;
            bus.out_data  <= s2_valid ? res_data : '0;
            bus.out_ovf   <= s2_valid & res_ovf;
            bus.out_unf   <= s2_valid & res_unf;
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: directed vectors plus randomized traffic
// scored against a value-level reference model.
module tb_fp_mul_pipe;
    localparam int EXP_W = 3;
    localparam int MAN_W = 4;
    localparam int BIAS  = 3;
    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int NOPS  = 500;

`ifdef FP_MUL_ROUND_EN
    localparam logic [W-1:0] EXP_33 = 8'h37;
`else
    localparam logic [W-1:0] EXP_33 = 8'h36;
`endif

    localparam logic [W-1:0] DIR_A [6] = '{8'h38, 8'hB8, 8'h33, 8'h7F, 8'h10, 8'h00};
    localparam logic [W-1:0] DIR_B [6] = '{8'h38, 8'h38, 8'h33, 8'h7F, 8'h10, 8'h38};
    localparam logic [W-1:0] DIR_R [6] = '{8'h42, 8'hC2, EXP_33, 8'h7F, 8'h00, 8'h00};
    localparam logic [1:0]   DIR_F [6] = '{2'b00, 2'b00, 2'b00, 2'b10, 2'b01, 2'b00};

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

    fp_mul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Reference: value = sigA*sigB * 2^(ea+eb-2*BIAS-2*MAN_W); renormalise to MAN_W+1 bits.
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
        int         ea, eb, e, msb, drop;
        longint     sa, sb, p, keep;
        logic       s, ovf, unf;
        logic [W-1:0] d;
        ea  = int'(a[W-2:MAN_W]);
        eb  = int'(b[W-2:MAN_W]);
        s   = a[W-1] ^ b[W-1];
        d   = '0;
        ovf = 1'b0;
        unf = 1'b0;
        if (ea == 0 || eb == 0) return {2'b00, d};
        sa  = (longint'(1) << MAN_W) + longint'(a[MAN_W-1:0]);
        sb  = (longint'(1) << MAN_W) + longint'(b[MAN_W-1:0]);
        p   = sa * sb;
        msb = 0;
        for (int i = 0; i < 40; i++) if (p[i]) msb = i;
        e    = ea + eb - BIAS - 2*MAN_W + msb;
        drop = msb - MAN_W;
        keep = p >> drop;
`ifdef FP_MUL_ROUND_EN
        begin
            longint rem, half;
            rem  = p - (keep << drop);
            half = longint'(1) << (drop - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
            if (keep == (longint'(1) << (MAN_W + 1))) begin
                keep = keep >> 1;
                e    = e + 1;
            end
        end
`endif
        if (e > (1 << EXP_W) - 1) begin
            d   = {s, {(W-1){1'b1}}};
            ovf = 1'b1;
        end else if (e < 1) begin
            unf = 1'b1;
        end else begin
            d = {s, e[EXP_W-1:0], keep[MAN_W-1:0]};
        end
        return {ovf, unf, d};
    endfunction

    task automatic run_single(input logic [W-1:0] a, input logic [W-1:0] b,
                              output logic [W-1:0] data, output logic [1:0] flags,
                              output int lat);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        lat   = 99;
        data  = 'x;
        flags = 'x;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                lat   = c;
                data  = bus.out_data;
                flags = {bus.out_ovf, bus.out_unf};
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'h38;
        bus.in_b      = 8'h38;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: got %b expected 0", bus.out_valid);
        end
        checks++;
        if ({bus.out_data, bus.out_ovf, bus.out_unf} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h/%b%b expected 00/00",
                     bus.out_data, bus.out_ovf, bus.out_unf);
        end
        @(posedge clk); #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] data;
        logic [1:0]   flags;
        int           lat;
        for (int i = 0; i < 6; i++) begin
            run_single(DIR_A[i], DIR_B[i], data, flags, lat);
            checks++;
            if (lat !== 3) begin
                errors++;
                $display("[TB] FAIL latency_%0d: got %0d expected 3", i, lat);
            end
            checks++;
            if (data !== DIR_R[i]) begin
                errors++;
                $display("[TB] FAIL data_%0d %h*%h: got %h expected %h",
                         i, DIR_A[i], DIR_B[i], data, DIR_R[i]);
            end
            checks++;
            if (flags !== DIR_F[i]) begin
                errors++;
                $display("[TB] FAIL flags_%0d: got %b expected %b", i, flags, DIR_F[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_seq [3];
        exp_seq[0] = 8'h30;
        exp_seq[1] = 8'h42;
        exp_seq[2] = EXP_33;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'h30;
        bus.in_b      = 8'h30;
        @(posedge clk); #1;
        bus.in_a = 8'h38;
        bus.in_b = 8'h38;
        @(posedge clk); #1;
        bus.in_a = 8'h33;
        bus.in_b = 8'h33;
        @(negedge clk);
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready_before: got %b expected 1", bus.in_ready);
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.out_data} !== {1'b0, 1'b1, 8'h30}) begin
            errors++;
            $display("[TB] FAIL b2b_stall_entry: got ready=%b valid=%b data=%h expected 0/1/30",
                     bus.in_ready, bus.out_valid, bus.out_data);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, 8'h30}) begin
                errors++;
                $display("[TB] FAIL b2b_hold_%0d: got %b/%h expected 1/30",
                         k, bus.out_valid, bus.out_data);
            end
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, exp_seq[k]}) begin
                errors++;
                $display("[TB] FAIL b2b_drain_%0d: got %b/%h expected 1/%h",
                         k, bus.out_valid, bus.out_data, exp_seq[k]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_empty: got %b expected 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        logic [W-1:0] data;
        logic [1:0]   flags;
        int           lat;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a      = 8'h38;
        bus.in_b      = 8'h38;
        @(posedge clk); #1;
        bus.in_a = 8'h33;
        bus.in_b = 8'h33;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if ({bus.out_valid, bus.out_data, bus.out_ovf, bus.out_unf} !== '0) begin
                errors++;
                $display("[TB] FAIL flush_%0d: got valid=%b data=%h flags=%b%b expected all 0",
                         k, bus.out_valid, bus.out_data, bus.out_ovf, bus.out_unf);
            end
            @(posedge clk);
        end
        run_single(8'h38, 8'h38, data, flags, lat);
        checks++;
        if ({lat, data, flags} !== {32'd3, 8'h42, 2'b00}) begin
            errors++;
            $display("[TB] FAIL post_reset_op: got lat=%0d data=%h flags=%b expected 3/42/00",
                     lat, data, flags);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] exp_q [$];
        logic [W+1:0] expect_word;
        logic [W+1:0] prev_out;
        logic         prev_stall;
        int           sent, cyc;
        sent       = 0;
        cyc        = 0;
        prev_stall = 1'b0;
        prev_out   = '0;
        while ((sent < NOPS || exp_q.size() != 0) && cyc < 20000) begin
            @(posedge clk); #1;
            bus.in_valid  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
            bus.in_a      = W'($urandom);
            bus.in_b      = W'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            cyc++;
            checks++;
            if (bus.in_ready !== !(bus.out_valid && !bus.out_ready)) begin
                errors++;
                $display("[TB] FAIL rand_in_ready: got %b with valid=%b ready=%b",
                         bus.in_ready, bus.out_valid, bus.out_ready);
            end
            if (prev_stall) begin
                checks++;
                if ({bus.out_valid, bus.out_ovf, bus.out_unf, bus.out_data} !== {1'b1, prev_out}) begin
                    errors++;
                    $display("[TB] FAIL rand_stall_hold: got %b/%h expected 1/%h",
                             bus.out_valid, {bus.out_ovf, bus.out_unf, bus.out_data}, prev_out);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(model(bus.in_a, bus.in_b));
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL rand_extra_result: got %h expected none", bus.out_data);
                end else begin
                    expect_word = exp_q.pop_front();
                    if ({bus.out_ovf, bus.out_unf, bus.out_data} !== expect_word) begin
                        errors++;
                        $display("[TB] FAIL rand_result: got flags=%b%b data=%h expected flags=%b data=%h",
                                 bus.out_ovf, bus.out_unf, bus.out_data,
                                 expect_word[W+1:W], expect_word[W-1:0]);
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_ovf, bus.out_unf, bus.out_data};
        end
        bus.in_valid = 1'b0;
        checks++;
        if (sent != NOPS || exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL rand_drain: got sent=%0d pending=%0d expected %0d/0",
                     sent, exp_q.size(), NOPS);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
